tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Upstream feeder for amp_control: turns queued note requests (colour/tone code plus duration in ms) into the `sound` half-period word (µs) and `play` gate.
- Buffers up to DEPTH notes in a FIFO.
- Plays each note for exactly its duration, then forces a fixed silent gap.
- Game FSM pushes Simon colour tones, error buzz and win chirps without timing them itself.

Parameters:
- CLK_PER_MS, 5000, clk cycles per millisecond; must be ≥2.
- DEPTH, 8, FIFO entries; power of 2, ≥2.
- GAP_MS, 50, silent ms after every note; 0 means no gap.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- note_in  input  3  tone code: 0 green, 1 red, 2 yellow, 3 blue, 4 error, 5 win, 6/7 rest
- dur_in  input  10  note duration in ms, 0..1023
- note_valid  input  1  producer offers note_in/dur_in
- note_ready  output  1  FIFO not full
- flush  input  1  synchronous abort; clears FIFO and the current note
- sound  output  13  half-period in µs, to amp_control
- play  output  1  tone gate, to amp_control
- busy  output  1  high while FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (reset=0, async): FIFO empty, FSM IDLE, sound=0, play=0, busy=0. note_ready=1 once reset releases.
- Accept: note_valid & note_ready at a rising edge pushes {note_in, dur_in}. note_ready = !full, combinational from FIFO count only.
- Full FIFO: note_valid is ignored; no push, no overflow corruption.
- Pop and push in the same cycle are both legal when not full. Count is unchanged.
- Tone table (sound value):
  - 0 → 1205
  - 1 → 1613
  - 2 → 1984
  - 3 → 2392
  - 4 → 5000
  - 5 → 568
  - 6/7 → sound unchanged, play stays 0 (rest)
- FSM states: IDLE, TONE, GAP.
- IDLE:
  - If FIFO non-empty: pop at this edge, register sound from the table, load dur_cnt = dur_in.
  - If dur_in ≠ 0: go to TONE.
  - If dur_in = 0: note is discarded; stay IDLE. The next entry may pop on the following edge.
- TONE:
  - play=1, except for rest codes.
  - ms prescaler restarts at 0 on entry.
  - dur_cnt decrements on each prescaler wrap (CLK_PER_MS cycles).
  - When dur_cnt reaches 0: play←0, go to GAP, or to IDLE if GAP_MS=0.
  - TONE therefore lasts exactly dur_in*CLK_PER_MS cycles.
- GAP:
  - play=0; sound holds its last value.
  - Lasts exactly GAP_MS*CLK_PER_MS cycles, then go to IDLE.
- Latency: note accepted at edge N into an empty, idle block → popped at edge N+1 → play=1 from edge N+2.
  - Back-to-back queued notes: IDLE costs exactly 1 cycle between GAP end and the next TONE.
- flush=1 at an edge:
  - FIFO emptied, FSM → IDLE, play←0, prescaler and dur_cnt cleared, sound holds.
  - flush has priority over a simultaneous push (the push is dropped) and over a pop.
- busy = (count≠0) | (state≠IDLE), registered-equivalent.
- All outputs except note_ready are registered. No combinational path from note_valid to any output.
- Reset asserted mid-note: play drops to 0 immediately (async); the queue is lost.

Optional Feature:
- Macro: TONE_DONE_EN.
- Defined:
  - Adds output `note_done` (1 bit): a one-cycle pulse on the edge the FSM returns to IDLE after a played or rest note.
  - Not pulsed for a dur_in=0 discard or for a flush.
  - Adds output `notes_played` (8 bits): wrapping count of note_done pulses, cleared by reset only.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset, then CLK_PER_MS=10, GAP_MS=2. Push note 2, dur 3 at edge N → sound=1984 and play=1 from N+2 for exactly 30 cycles, play=0 for 20 cycles, then busy=0.
- Push notes 0,1,3 with dur 1 back-to-back → sound sequence 1205,1613,2392. Each play pulse is 10 cycles; gaps are 20 cycles plus 1 IDLE cycle.
- Hold note_valid with the FSM stalled in a long note (dur 100) → exactly 8 accepted, note_ready=0. Extra offers are dropped; all 8 play in order.
- Push rest code 6 dur 2 followed by note 4 dur 1 → play stays 0 for 20+20 cycles, then sound=5000, play=1 for 10 cycles.
- Push dur 0 note 5, then note 1 dur 1 → sound never 568, no play pulse for it; 1613 plays starting 1 cycle later than the normal latency.
- Assert flush 5 cycles into a tone with 3 queued, while note_valid=1 → play=0 next edge, busy=0, no push. With TONE_DONE_EN, note_done is not pulsed and notes_played is unchanged.

Source files
------------

// File: rtl/tone_sequencer.sv
// Buffers note requests in a FIFO and plays each as a timed tone gate plus silent gap for amp_control.
// Optional macro TONE_DONE_EN adds the note_done pulse and the notes_played counter.
module tone_sequencer #(
  parameter int CLK_PER_MS = 5000,
  parameter int DEPTH      = 8,
  parameter int GAP_MS     = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  note_in,
  input  logic [9:0]  dur_in,
  input  logic        note_valid,
  output logic        note_ready,
  input  logic        flush,
  output logic [12:0] sound,
  output logic        play,
  output logic        busy
`ifdef TONE_DONE_EN
  ,
  output logic        note_done,
  output logic [7:0]  notes_played
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(CLK_PER_MS);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_PER_MS - 1);
  localparam logic [9:0]    GAP_LEN  = 10'(GAP_MS);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  // Rest codes leave the previous half-period in place.
  function automatic logic [12:0] tone_lut(input logic [2:0] code, input logic [12:0] cur);
    case (code)
      3'd0:    return 13'd1205;
      3'd1:    return 13'd1613;
      3'd2:    return 13'd1984;
      3'd3:    return 13'd2392;
      3'd4:    return 13'd5000;
      3'd5:    return 13'd568;
      default: return cur;
    endcase
  endfunction

  logic [12:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_pre;
  logic [9:0]    r_dur;
  logic          r_rest, r_play;
  logic [12:0]   r_sound;
  logic [12:0]   w_head;
  logic          w_full, w_push, w_pop, w_wrap, w_last;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_full     = (r_count == FULL_CNT);
  assign w_push     = note_valid & ~w_full & ~flush;
  assign w_wrap     = (r_pre == PRE_MAX);
  assign w_last     = w_wrap & (r_dur == 10'd1);
  assign note_ready = ~w_full;
  assign busy       = (r_count != '0) | (r_state != IDLE);
  assign sound      = r_sound;
  assign play       = r_play;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {note_in, dur_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_count != '0) begin
            w_pop = 1'b1;
            if (w_head[9:0] != 10'd0) w_state_nxt = TONE;
          end
        end
        TONE:    if (w_last) w_state_nxt = (GAP_MS == 0) ? IDLE : GAP;
        GAP:     if (w_last) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // One shared ms prescaler times both the tone and the gap; r_dur holds the remaining ms.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre   <= '0;
      r_dur   <= '0;
      r_rest  <= 1'b0;
      r_sound <= '0;
      r_play  <= 1'b0;
    end else if (flush) begin
      r_pre  <= '0;
      r_dur  <= '0;
      r_play <= 1'b0;
    end else begin
      r_play <= (r_state == TONE) & ~r_rest;
      if (r_state == IDLE) begin
        r_pre <= '0;
        if (w_pop) begin
          r_dur  <= w_head[9:0];
          r_rest <= (w_head[12:11] == 2'b11);
          if (w_head[9:0] != 10'd0) r_sound <= tone_lut(w_head[12:10], r_sound);
        end
      end else if (w_last) begin
        r_pre <= '0;
        r_dur <= (r_state == TONE) ? GAP_LEN : 10'd0;
      end else begin
        r_pre <= w_wrap ? '0 : r_pre + PW'(1);
        if (w_wrap) r_dur <= r_dur - 10'd1;
      end
    end
  end

`ifdef TONE_DONE_EN
  logic       r_done;
  logic [7:0] r_played;
  logic       w_done;

  assign w_done       = ~flush & (r_state != IDLE) & (w_state_nxt == IDLE);
  assign note_done    = r_done;
  assign notes_played = r_played;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done   <= 1'b0;
      r_played <= '0;
    end else begin
      r_done <= w_done;
      if (w_done) r_played <= r_played + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: expected tones queued at push, checked at each play pulse.
module tb_tone_sequencer;
  localparam int CPM   = 10;
  localparam int DEPTH = 8;
  localparam int GAPMS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  note_in = '0;
  logic [9:0]  dur_in = '0;
  logic        note_valid = 1'b0;
  logic        note_ready;
  logic        flush = 1'b0;
  logic [12:0] sound;
  logic        play;
  logic        busy;
`ifdef TONE_DONE_EN
  logic        note_done;
  logic [7:0]  notes_played;
`endif

  tone_sequencer #(.CLK_PER_MS(CPM), .DEPTH(DEPTH), .GAP_MS(GAPMS)) dut (
    .clk(clk), .reset(reset), .note_in(note_in), .dur_in(dur_in),
    .note_valid(note_valid), .note_ready(note_ready), .flush(flush),
    .sound(sound), .play(play), .busy(busy)
`ifdef TONE_DONE_EN
    , .note_done(note_done), .notes_played(notes_played)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int snd; int len; int rise; int gap;} exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int exp_done = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int lut(input int n);
    case (n)
      0: return 1205;
      1: return 1613;
      2: return 1984;
      3: return 2392;
      4: return 5000;
      5: return 568;
      default: return -1;
    endcase
  endfunction

  // Monitor: at every play rise pop the next expected tone; at every fall check its length.
  exp_t cur = '{-1, -1, -1, -1};
  int   hi_len = 0;
  int   low_len = 0;
  logic prev_play = 1'b0;
  bit   seen568 = 1'b0;
  always @(negedge clk) begin
    if (sound == 13'd568) seen568 = 1'b1;
    if (play && !prev_play) begin
      if (q.size() == 0) begin
        check("unexpected_play", 1, 0);
        cur = '{-1, -1, -1, -1};
      end else begin
        cur = q.pop_front();
        check("sound", int'(sound), cur.snd);
        if (cur.rise >= 0) check("rise_cycle", cyc, cur.rise);
        if (cur.gap >= 0) check("gap_len", low_len, cur.gap);
      end
      hi_len = 1;
    end else if (play) begin
      hi_len++;
    end else if (prev_play) begin
      if (cur.len >= 0) check("play_len", hi_len, cur.len);
      low_len = 1;
    end else begin
      low_len++;
    end
    prev_play = play;
  end

  task automatic offer(input int n, input int d, input bit sb, input int len,
                       input int rise_rel, input int gap);
    note_in = 3'(n);
    dur_in = 10'(d);
    note_valid = 1'b1;
    @(posedge clk); #1;
    note_valid = 1'b0;
    if (sb && d != 0) begin
      exp_done++;
      if (n < 6) q.push_back('{lut(n), len, (rise_rel < 0) ? -1 : cyc + rise_rel, gap});
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) check(tag, int'(busy), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int occ;
`ifdef TONE_DONE_EN
    int np;
`endif
    repeat (3) @(negedge clk);
    check("rst_sound", int'(sound), 0);
    check("rst_play", int'(play), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    check("rst_ready", int'(note_ready), 1);
    repeat (2) @(posedge clk); #1;

    // single note: latency, 30-cycle tone, 20-cycle gap
    offer(2, 3, 1'b1, 3 * CPM, 2, -1);
    check("busy_after_push", int'(busy), 1);
    @(posedge clk); #1;
    check("play_n1", int'(play), 0);
    @(posedge clk); #1;
    check("play_n2", int'(play), 1);
    check("sound_n2", int'(sound), 1984);
    repeat (48) @(posedge clk); #1;
    check("busy_in_gap", int'(busy), 1);
    check("play_in_gap", int'(play), 0);
    @(posedge clk); #1;
    check("busy_done", int'(busy), 0);
    wait_idle("idle_t1");

    // back-to-back queued notes
    offer(0, 1, 1'b1, CPM, 2, -1);
    offer(1, 1, 1'b1, CPM, -1, GAPMS * CPM + 1);
    offer(3, 1, 1'b1, CPM, -1, GAPMS * CPM + 1);
    wait_idle("idle_t2");

    // fill the FIFO behind a long note
    offer(0, 100, 1'b1, 100 * CPM, 2, -1);
    repeat (4) @(posedge clk); #1;
    occ = 0;
    note_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      note_in = 3'(i % 6);
      dur_in = 10'd1;
      check("ready_fill", int'(note_ready), int'(occ < DEPTH));
      if (occ < DEPTH) begin
        occ++;
        exp_done++;
        q.push_back('{lut(i % 6), CPM, -1, GAPMS * CPM + 1});
      end
      @(posedge clk); #1;
    end
    note_valid = 1'b0;
    check("ready_full", int'(note_ready), 0);
    wait_idle("idle_t3");

    // rest then error buzz
    offer(6, 2, 1'b1, -1, -1, -1);
    offer(4, 1, 1'b1, CPM, 2 * CPM + GAPMS * CPM + 2, -1);
    wait_idle("idle_t4");

    // zero-duration discard
    seen568 = 1'b0;
    offer(5, 0, 1'b1, -1, -1, -1);
    offer(1, 1, 1'b1, CPM, 2, -1);
    wait_idle("idle_t5");
    check("no_568", int'(seen568), 0);

    // flush mid-tone with three queued and a simultaneous offer
    offer(2, 5, 1'b1, -1, 2, -1);
    offer(0, 1, 1'b0, -1, -1, -1);
    offer(1, 1, 1'b0, -1, -1, -1);
    offer(3, 1, 1'b0, -1, -1, -1);
    @(posedge clk);
    @(posedge clk); #1;
    check("tone_on", int'(play), 1);
`ifdef TONE_DONE_EN
    np = int'(notes_played);
`endif
    flush = 1'b1;
    note_valid = 1'b1;
    note_in = 3'd3;
    dur_in = 10'd1;
    @(posedge clk); #1;
    flush = 1'b0;
    note_valid = 1'b0;
    exp_done--;
    check("flush_play", int'(play), 0);
    check("flush_busy", int'(busy), 0);
    check("flush_ready", int'(note_ready), 1);
`ifdef TONE_DONE_EN
    check("flush_done", int'(note_done), 0);
    check("flush_played", int'(notes_played), np);
`endif
    repeat (3) @(posedge clk); #1;
    check("post_flush_busy", int'(busy), 0);
    check("post_flush_play", int'(play), 0);
`ifdef TONE_DONE_EN
    check("notes_played", int'(notes_played), exp_done % 256);
`endif

    // asynchronous reset in the middle of a tone
    offer(3, 5, 1'b1, -1, 2, -1);
    repeat (4) @(posedge clk);
    @(negedge clk); #2;
    check("pre_rst_play", int'(play), 1);
    reset = 1'b0;
    #1;
    check("arst_play", int'(play), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_sound", int'(sound), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("arst_idle", int'(busy), 0);
    check("arst_ready", int'(note_ready), 1);
    check("sb_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
